// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_e;

    localparam int unsigned WRITE_COUNT_W = 16;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer request bus and FIFO write-port bundle for fifo_write_arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic [WIDTH-1:0]         fifo_data;
    logic                     fifo_write_ins;

    // master: producers plus the FIFO; slave: the arbiter
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_data, fifo_write_ins
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_data, fifo_write_ins
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after 'last', wrapping at NUM_REQ-1.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    winner
);
    localparam int IW = ID_W + 1;

    logic [IW-1:0] idx;

    // one extra bit so last+offset cannot overflow before the modulo fold
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = {1'b0, last} + IW'(off);
            if (idx >= IW'(NUM_REQ)) begin
                idx = idx - IW'(NUM_REQ);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among NUM_REQ valid/ready producers; each grant
// becomes a registered one-cycle write_ins pulse followed by at least one idle cycle.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arb_enable,
    fifo_write_arbiter_if.slave      bus,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic [WRITE_COUNT_W-1:0] write_count
);

    arb_state_e               state_q, state_d;
    logic                     grant;
    logic                     found;
    logic [ID_W-1:0]          winner;
    logic [ID_W-1:0]          last_grant_q;
    logic [ID_W-1:0]          grant_id_q;
    logic [WIDTH-1:0]         data_q;
    logic [WIDTH-1:0]         sel_data;
    logic [NUM_REQ-1:0]       ready_q;
    logic [NUM_REQ-1:0]       ready_d;
    logic                     write_q;
    logic [WRITE_COUNT_W-1:0] count_q;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req   (bus.req_valid),
        .last  (last_grant_q),
        .found (found),
        .winner(winner)
    );

    always_comb begin
        sel_data = '0;
        ready_d  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_data   = bus.req_data[i*WIDTH +: WIDTH];
                ready_d[i] = 1'b1;
            end
        end
    end

    // fifo_full is only looked at in IDLE, one cycle after the previous pulse
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_enable && !bus.fifo_full && found) begin
                    grant   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            ready_q      <= '0;
            data_q       <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            write_q <= grant;
            ready_q <= grant ? ready_d : '0;
            if (grant) begin
                data_q       <= sel_data;
                grant_id_q   <= winner;
                last_grant_q <= winner;
            end
            if (state_q == ST_WRITE) begin
                count_q <= count_q + WRITE_COUNT_W'(1);
            end
        end
    end

    assign bus.fifo_write_ins = write_q;
    assign bus.req_ready      = ready_q;
    assign bus.fifo_data      = data_q;
    assign grant_id           = grant_id_q;
    assign busy               = (state_q == ST_WRITE);
    assign write_count        = count_q;

    a_single_cycle_write: assert property (@(posedge clk) disable iff (rst) write_q |=> !write_q);
    a_ready_onehot0:      assert property (@(posedge clk) $onehot0(ready_q));
    a_ready_tracks_write: assert property (@(posedge clk) (|ready_q) == write_q);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: 4-requester instance with a depth-4
// FIFO model, plus a 3-requester instance for the non-power-of-2 wrap.
module tb_fifo_write_arbiter;
    localparam int N     = 4;
    localparam int N3    = 3;
    localparam int DEPTH = 4;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arb_en = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(N),  .WIDTH(8)) bus  ();
    fifo_write_arbiter_if #(.NUM_REQ(N3), .WIDTH(8)) bus3 ();

    logic [1:0]  gid, gid3;
    logic        busy, busy3;
    logic [15:0] wcnt, wcnt3;

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .arb_enable(arb_en), .bus(bus),
        .grant_id(gid), .busy(busy), .write_count(wcnt)
    );

    fifo_write_arbiter #(.NUM_REQ(N3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .arb_enable(1'b1), .bus(bus3),
        .grant_id(gid3), .busy(busy3), .write_count(wcnt3)
    );

    // requester model: valid while fewer acceptances seen than requested
    int         target [N]  = '{default: 0};
    int         served [N]  = '{default: 0};
    int         target3[N3] = '{default: 0};
    int         served3[N3] = '{default: 0};
    logic [7:0] rdata  [N]  = '{default: 8'h00};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = served[i] < target[i];
            bus.req_data[i*8 +: 8]   = rdata[i];
        end
        for (int i = 0; i < N3; i++) begin
            bus3.req_valid[i] = served3[i] < target3[i];
        end
    end
    assign bus3.req_data  = {8'h32, 8'h31, 8'h30};
    assign bus3.fifo_full = 1'b0;

    // FIFO occupancy model, active only when fmodel is set
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic fmodel = 1'b0;
    always @(posedge bus.fifo_write_ins) wr_cnt <= wr_cnt + 1;
    assign bus.fifo_full = fmodel && ((wr_cnt - rd_cnt) >= DEPTH);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    exp_t q3[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   phase = 0, exp_gap = 0, exp_lat = 0, req_cyc = 0;

    task automatic chk(input string name, input longint act, input longint want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic expect_w(input int id, input logic [7:0] d);
        q.push_back(exp_t'{id: id, data: d});
    endtask

    task automatic expect3(input int id, input logic [7:0] d);
        q3.push_back(exp_t'{id: id, data: d});
    endtask

    int   exp_wc = 0, exp_wc3 = 0;
    int   wait_cyc = 0, wait3 = 0;
    int   last_pulse_cyc = 0, last_pulse_phase = -1;
    logic rst_prev = 1'b0, wr_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            chk("reset write_ins", bus.fifo_write_ins, 0);
            chk("reset req_ready", bus.req_ready, 0);
            chk("reset busy", busy, 0);
            chk("reset fifo_data", bus.fifo_data, 0);
            chk("reset grant_id", gid, 0);
            chk("reset write_count", wcnt, 0);
            chk("dut3 reset write_count", wcnt3, 0);
            exp_wc  = 0;
            exp_wc3 = 0;
        end else begin
            chk("write_count", wcnt, exp_wc);
            chk("dut3 write_count", wcnt3, exp_wc3);
            if (bus.fifo_write_ins) begin
                chk("back-to-back write", wr_prev, 0);
                if (fmodel) chk("write into full fifo", (wr_cnt - rd_cnt) <= DEPTH, 1);
                if (q.size() == 0) begin
                    chk("unexpected write", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("grant_id", gid, e.id);
                    chk("fifo_data", bus.fifo_data, e.data);
                    chk("req_ready", bus.req_ready, 64'(1) << e.id);
                    chk("busy in write", busy, 1);
                end
                if (exp_lat != 0 && last_pulse_phase != phase) chk("grant latency", cyc - req_cyc, exp_lat);
                if (exp_gap != 0 && last_pulse_phase == phase) chk("pulse spacing", cyc - last_pulse_cyc, exp_gap);
                last_pulse_cyc   = cyc;
                last_pulse_phase = phase;
                exp_wc   = (exp_wc + 1) % 65536;
                wait_cyc = 0;
            end else begin
                chk("idle req_ready", bus.req_ready, 0);
                chk("idle busy", busy, 0);
                if (q.size() != 0) begin
                    wait_cyc++;
                    if (wait_cyc > 40) begin
                        chk("write timeout", q.size(), 0);
                        q.delete();
                        wait_cyc = 0;
                    end
                end
            end
            chk("dut3 grant_id range", gid3 < 2'd3, 1);
            if (bus3.fifo_write_ins) begin
                if (q3.size() == 0) begin
                    chk("dut3 unexpected write", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("dut3 grant_id", gid3, e.id);
                    chk("dut3 fifo_data", bus3.fifo_data, e.data);
                    chk("dut3 req_ready", bus3.req_ready, 64'(1) << e.id);
                    chk("dut3 busy", busy3, 1);
                end
                exp_wc3 = (exp_wc3 + 1) % 65536;
                wait3   = 0;
            end else if (q3.size() != 0) begin
                wait3++;
                if (wait3 > 40) begin
                    chk("dut3 write timeout", q3.size(), 0);
                    q3.delete();
                    wait3 = 0;
                end
            end
        end
        for (int i = 0; i < N; i++)  if (bus.req_ready[i])  served[i]++;
        for (int i = 0; i < N3; i++) if (bus3.req_ready[i]) served3[i]++;
        wr_prev  = bus.fifo_write_ins;
        rst_prev = rst;
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (q.size() == 0 && q3.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0 || q3.size() != 0) begin
            $display("FAIL drain: %0d writes still outstanding", q.size() + q3.size());
            $fatal(1, "scoreboard stuck");
        end
        settle(3);
    endtask

    task automatic wait_pulse();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.fifo_write_ins) break;
        end
    endtask

    initial begin
        settle(3);
        rst    = 1'b0;
        arb_en = 1'b1;

        // single requester from reset
        phase = 1; exp_lat = 1;
        rdata[0] = 8'hA5;
        expect_w(0, 8'hA5);
        req_cyc   = cyc;
        target[0] = served[0] + 1;
        drain();

        // all four requesting from a fresh reset: 0,1,2,3,0,1,2,3
        rst = 1'b1; settle(2); rst = 1'b0;
        phase = 2; exp_lat = 1; exp_gap = 2;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) expect_w(i, 8'h10 + 8'(i));
        req_cyc = cyc;
        for (int i = 0; i < N; i++) begin
            rdata[i]  = 8'h10 + 8'(i);
            target[i] = served[i] + 2;
        end
        drain();

        // arb_enable low: nothing; then drop it during the write
        phase = 3; exp_lat = 0; exp_gap = 0;
        arb_en = 1'b0;
        rdata[1] = 8'h21; rdata[3] = 8'h23;
        target[1] = served[1] + 1;
        target[3] = served[3] + 1;
        settle(10);
        expect_w(1, 8'h21);
        arb_en = 1'b1;
        wait_pulse();
        arb_en = 1'b0;
        settle(10);
        expect_w(3, 8'h23);
        arb_en = 1'b1;
        drain();

        // full back-pressure with requester 2 streaming
        phase = 4;
        rd_cnt = wr_cnt;
        fmodel = 1'b1;
        rdata[2] = 8'h42;
        for (int i = 0; i < DEPTH; i++) expect_w(2, 8'h42);
        target[2] = served[2] + 100;
        drain();
        settle(10);
        expect_w(2, 8'h42);
        rd_cnt = rd_cnt + 1;
        drain();
        settle(10);
        target[2] = served[2];
        fmodel    = 1'b0;
        settle(2);

        // reset mid-write: requester 0 wins again afterwards
        phase = 5;
        rdata[0] = 8'h50; rdata[2] = 8'h52;
        expect_w(0, 8'h50);
        target[0] = served[0] + 2;
        target[2] = served[2] + 1;
        wait_pulse();
        rst = 1'b1;
        expect_w(0, 8'h50);
        expect_w(2, 8'h52);
        settle(2);
        rst = 1'b0;
        drain();

        // three requesters: 0,1,2,0
        phase = 6;
        expect3(0, 8'h30); expect3(1, 8'h31); expect3(2, 8'h32); expect3(0, 8'h30);
        target3[0] = served3[0] + 2;
        target3[1] = served3[1] + 1;
        target3[2] = served3[2] + 1;
        drain();
        settle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares one `fifo_module` write port between `NUM_REQ` producers (UART RX, dual-core store paths, DMA). It accepts valid/ready requests, picks one winner per slot, and drives the FIFO's edge-triggered `write_ins` as a clean one-cycle pulse. Write pulses are separated by at least one low cycle, so `full` has settled before the next decision. It sits between producer blocks and the FIFO's `data_bus_in`, `write_ins` and `full` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: data width; must equal the FIFO `WIDTH`.
- `ID_W`, `$clog2(NUM_REQ)`: grant index width; derived, do not override.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `arb_enable`  in  1  when low, no new grant is issued; an in-flight write completes.
- `req_valid`  in  NUM_REQ  per-requester request; held high, with data stable, until that requester's ready pulse.
- `req_data`  in  NUM_REQ*WIDTH  requester i data is at bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  one-cycle acceptance pulse; one-hot or zero.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_data`  out  WIDTH  to FIFO `data_bus_in`; registered.
- `fifo_write_ins`  out  1  to FIFO `write_ins`; registered, a one-cycle pulse.
- `grant_id`  out  ID_W  index of the last granted requester.
- `busy`  out  1  high while in WRITE.
- `write_count`  out  16  number of accepted writes; wraps at 65535→0.

## Operation
- The FSM has 2 states, IDLE and WRITE.
- **IDLE**: a grant is issued if `arb_enable`, `!fifo_full` and `|req_valid`. On a grant:
  - winner w is selected round-robin;
  - `fifo_data` ← `req_data[w]`;
  - `grant_id` ← w, `last_grant` ← w;
  - go to WRITE.
  - Otherwise stay in IDLE with all strobes low.
- **WRITE**, exactly 1 cycle:
  - `fifo_write_ins` = 1, `req_ready[grant_id]` = 1, `busy` = 1;
  - `write_count` increments;
  - unconditionally return to IDLE.
- **Round-robin**: search starts at `last_grant+1` and wraps modulo `NUM_REQ`. The first requester with valid high wins. Non-power-of-2 `NUM_REQ` wraps at `NUM_REQ-1`→0, never through an unused index.
- Requesters that are not granted keep their valid and data asserted. There is no timeout and no drop.
- `fifo_data` holds its value after WRITE until the next grant.
- `arb_enable` falling during WRITE: the write completes and no further grant is issued.

## Timing
- **Reset values**: state IDLE, `fifo_write_ins` 0, `req_ready` 0, `busy` 0, `fifo_data` 0, `grant_id` 0, `write_count` 0, `last_grant` = NUM_REQ-1 (so requester 0 wins first).
- **Latency**: `req_valid` sampled high in IDLE at edge N → `fifo_write_ins` and `req_ready` high during cycle N+1 → low in cycle N+2.
- **Throughput**: at most one write per 2 cycles; `fifo_write_ins` is never high on 2 consecutive cycles.
- **Full settling**: the FIFO updates `full` off the `write_ins` rising edge within the WRITE cycle. The next IDLE decision samples the updated `full`, so a write is never issued into a full FIFO.
- **Simultaneous requests**: exactly one grant per slot; the others wait, with a worst-case wait of 2*(NUM_REQ-1) cycles.
- **Requester drops valid** in the grant cycle: not allowed; the data has already been captured, so the write proceeds.
- **Reset mid-WRITE**: at the next edge `fifo_write_ins` and `req_ready` go to 0, and no further rising edge is generated. The FIFO's `rst_n` is driven from `~rst` at the top level, so queue pointers reset concurrently.

## Structure
- Package `fifo_arb_pkg`:
  - state encoding constants `ST_IDLE` = 1'b0, `ST_WRITE` = 1'b1;
  - `WRITE_COUNT_W` = 16.
- Sub-module `rr_picker`, purely combinational:
  - inputs `req[NUM_REQ]`, `last[ID_W]`;
  - outputs `found`, `winner[ID_W]`.
- Top-level contents: FSM, data register, counter and output registers.

## Test plan
- **Single requester**: req_valid=4'b0001, data 8'hA5, FIFO empty → `fifo_write_ins` pulse 1 cycle after sampling, `fifo_data`=A5, `req_ready`=0001 in the same cycle, `write_count`=1.
- **All four requesting continuously**, data 8'h10..8'h13 → grant order 0,1,2,3,0,…, FIFO contents 10,11,12,13,10…, one pulse every 2 cycles.
- **Full back-pressure**: FIFO DEPTH=4, requester 2 streaming → exactly 4 pulses; `req_ready` stays low while `fifo_full`=1. One FIFO read → exactly one more write.
- **arb_enable low** with requesters active → no pulses. Deassert `arb_enable` during WRITE → the current write completes and the next IDLE issues no grant.
- **NUM_REQ=3** with all valid → grants 0,1,2,0; grant_id never equals 3.
- **rst asserted during WRITE** → next cycle `fifo_write_ins`=0, `write_count`=0, and the next grant goes to requester 0.
